// File: rtl/map_seq_ctrl.sv
// Control sequencer for the sliding-window MAP decoder: walks LOAD, GAMMA and per-window
// FWD/DUMMY/BWD phases, driving RAM strobes, recursion seed selects and address-counter resets.
module map_seq_ctrl #(
  parameter int FRAME_LEN = 64,
  parameter int WIN_LEN   = 16,
  parameter int LLR_LAT   = 1
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       start,
  output logic       busy,
  output logic       done,
  output logic       llr_valid,
  output logic [7:0] win_idx,
  output logic       in_rdwr1,
  output logic       in_rdwr2,
  output logic       gamma_rdwr1,
  output logic       gamma_rdwr2,
  output logic       alpha_rdwr1,
  output logic       alpha_rdwr2,
  output logic       mux_alpha,
  output logic       mux_dummy,
  output logic       mux_beta,
  output logic       reset_input,
  output logic       reset_gamma,
  output logic       reset2_gamma,
  output logic       reset3_gamma,
  output logic       reset_alpha
);

  localparam int CNT_W   = $clog2(FRAME_LEN) + 1;
  localparam int NUM_WIN = FRAME_LEN / WIN_LEN;
  localparam logic [CNT_W-1:0] LAST_N   = CNT_W'(FRAME_LEN - 1);
  localparam logic [CNT_W-1:0] LAST_W   = CNT_W'(WIN_LEN - 1);
  localparam logic [7:0]       LAST_WIN = 8'(NUM_WIN - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_GAMMA, S_FWD, S_DUMMY, S_BWD, S_DONE
  } state_t;

  state_t             state, state_nxt;
  logic [CNT_W-1:0]   cnt;
  logic               phase_end;
  logic               first_cyc;
  logic               last_win;
  logic               bwd_act;
  logic [LLR_LAT-1:0] llr_vld_p;

  always_comb begin
    phase_end = 1'b0;
    case (state)
      S_LOAD, S_GAMMA:       phase_end = (cnt == LAST_N);
      S_FWD, S_DUMMY, S_BWD: phase_end = (cnt == LAST_W);
      default:               phase_end = 1'b0;
    endcase
  end

  assign first_cyc = (cnt == '0);
  assign last_win  = (win_idx == LAST_WIN);
  assign bwd_act   = (state == S_BWD);

  always_ff @(posedge clock) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (start)     state_nxt = S_LOAD;
      S_LOAD:  if (phase_end) state_nxt = S_GAMMA;
      S_GAMMA: if (phase_end) state_nxt = S_FWD;
      S_FWD:   if (phase_end) state_nxt = S_DUMMY;
      S_DUMMY: if (phase_end) state_nxt = S_BWD;
      S_BWD:   if (phase_end) state_nxt = last_win ? S_DONE : S_FWD;
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Phase counter restarts at every state change, so it indexes the cycle within the phase.
  always_ff @(posedge clock) begin
    if (reset)                   cnt <= '0;
    else if (state_nxt != state) cnt <= '0;
    else if (state != S_IDLE)    cnt <= cnt + CNT_W'(1);
  end

  always_ff @(posedge clock) begin
    if (reset)                                  win_idx <= 8'd0;
    else if (state == S_GAMMA && phase_end)     win_idx <= 8'd0;
    else if (bwd_act && phase_end && !last_win) win_idx <= win_idx + 8'd1;
  end

  always_comb begin
    busy         = (state != S_IDLE);
    done         = 1'b0;
    in_rdwr1     = 1'b0;
    in_rdwr2     = 1'b0;
    gamma_rdwr1  = 1'b0;
    gamma_rdwr2  = 1'b0;
    alpha_rdwr1  = 1'b0;
    alpha_rdwr2  = 1'b0;
    mux_alpha    = 1'b0;
    mux_dummy    = 1'b0;
    mux_beta     = 1'b0;
    reset_input  = 1'b0;
    reset_gamma  = 1'b0;
    reset2_gamma = 1'b0;
    reset3_gamma = 1'b0;
    reset_alpha  = 1'b0;
    case (state)
      S_IDLE: begin
        reset_input  = 1'b1;
        reset_gamma  = 1'b1;
        reset2_gamma = 1'b1;
        reset3_gamma = 1'b1;
        reset_alpha  = 1'b1;
      end
      S_LOAD: begin
        in_rdwr1    = 1'b1;
        reset_input = phase_end;
        reset_gamma = phase_end;
      end
      S_GAMMA: begin
        in_rdwr2    = 1'b1;
        gamma_rdwr1 = 1'b1;
        reset_gamma = phase_end;
        reset_alpha = phase_end;
      end
      S_FWD: begin
        gamma_rdwr2  = 1'b1;
        alpha_rdwr1  = 1'b1;
        mux_alpha    = first_cyc && (win_idx == 8'd0);
        reset2_gamma = phase_end;
      end
      S_DUMMY: begin
        gamma_rdwr2  = 1'b1;
        mux_dummy    = first_cyc;
        reset3_gamma = phase_end;
        reset_alpha  = phase_end;
      end
      S_BWD: begin
        gamma_rdwr2 = 1'b1;
        alpha_rdwr2 = 1'b1;
        mux_beta    = first_cyc;
        reset_alpha = phase_end && !last_win;
      end
      S_DONE: done = 1'b1;
      default: ;
    endcase
  end

  // LLR valid pipeline: BWD activity delayed by the datapath LLR latency
  generate
    if (LLR_LAT == 1) begin : g_lat1
      always_ff @(posedge clock) begin
        if (reset) llr_vld_p <= '0;
        else       llr_vld_p <= bwd_act;
      end
    end else begin : g_latn
      always_ff @(posedge clock) begin
        if (reset) llr_vld_p <= '0;
        else       llr_vld_p <= {llr_vld_p[LLR_LAT-2:0], bwd_act};
      end
    end
  endgenerate

  assign llr_valid = llr_vld_p[LLR_LAT-1];

endmodule

// File: tb/tb_map_seq_ctrl.sv
// Directed bench for map_seq_ctrl: default 64/16/1 instance for frame timing, restart and
// mid-frame reset, plus a 16/16/3 instance for the single-window, long-latency case.
module tb_map_seq_ctrl;

  logic       clock;
  logic       reset;
  logic       start;
  logic       start6;

  logic       busy, done, llr_valid;
  logic [7:0] win_idx;
  logic       in_rdwr1, in_rdwr2, gamma_rdwr1, gamma_rdwr2, alpha_rdwr1, alpha_rdwr2;
  logic       mux_alpha, mux_dummy, mux_beta;
  logic       reset_input, reset_gamma, reset2_gamma, reset3_gamma, reset_alpha;

  logic       busy6, done6, llr_valid6;
  logic [7:0] win_idx6;
  logic       in1_6, in2_6, g1_6, g2_6, a1_6, a2_6, ma6, md6, mb6;
  logic       rin6, rg6, r2g6, r3g6, ra6;

  int n_cmp = 0;
  int n_bad = 0;

  map_seq_ctrl u_dut (
    .clock(clock), .reset(reset), .start(start),
    .busy(busy), .done(done), .llr_valid(llr_valid), .win_idx(win_idx),
    .in_rdwr1(in_rdwr1), .in_rdwr2(in_rdwr2),
    .gamma_rdwr1(gamma_rdwr1), .gamma_rdwr2(gamma_rdwr2),
    .alpha_rdwr1(alpha_rdwr1), .alpha_rdwr2(alpha_rdwr2),
    .mux_alpha(mux_alpha), .mux_dummy(mux_dummy), .mux_beta(mux_beta),
    .reset_input(reset_input), .reset_gamma(reset_gamma),
    .reset2_gamma(reset2_gamma), .reset3_gamma(reset3_gamma), .reset_alpha(reset_alpha)
  );

  map_seq_ctrl #(.FRAME_LEN(16), .WIN_LEN(16), .LLR_LAT(3)) u_dut6 (
    .clock(clock), .reset(reset), .start(start6),
    .busy(busy6), .done(done6), .llr_valid(llr_valid6), .win_idx(win_idx6),
    .in_rdwr1(in1_6), .in_rdwr2(in2_6),
    .gamma_rdwr1(g1_6), .gamma_rdwr2(g2_6),
    .alpha_rdwr1(a1_6), .alpha_rdwr2(a2_6),
    .mux_alpha(ma6), .mux_dummy(md6), .mux_beta(mb6),
    .reset_input(rin6), .reset_gamma(rg6),
    .reset2_gamma(r2g6), .reset3_gamma(r3g6), .reset_alpha(ra6)
  );

  logic [16:0] obs_main;
  logic [6:0]  obs6;
  assign obs_main = {busy, done, llr_valid, in_rdwr1, in_rdwr2, gamma_rdwr1, gamma_rdwr2,
                     alpha_rdwr1, alpha_rdwr2, mux_alpha, mux_dummy, mux_beta,
                     reset_input, reset_gamma, reset2_gamma, reset3_gamma, reset_alpha};
  assign obs6 = {busy6, done6, llr_valid6, g2_6, ma6, md6, mb6};

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_cmp++;
    assert (obs === exp_v) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  // N=64, W=16, LLR_LAT=1; k = cycles after the edge that sampled start
  function automatic logic is_bwd(input int k);
    return (k >= 129) && (k <= 320) && (((k - 129) % 48) >= 32);
  endfunction

  function automatic logic [16:0] exp_main(input int k);
    logic [16:0] v;
    int o;
    int w;
    v = '0;
    if (k <= 0 || k >= 322) begin
      v[4:0] = 5'b11111;
      return v;
    end
    v[16] = 1'b1;
    if (k <= 64) begin
      v[13] = 1'b1;
      if (k == 64) begin v[4] = 1'b1; v[3] = 1'b1; end
    end else if (k <= 128) begin
      v[12] = 1'b1;
      v[11] = 1'b1;
      if (k == 128) begin v[3] = 1'b1; v[0] = 1'b1; end
    end else if (k <= 320) begin
      w = (k - 129) / 48;
      o = (k - 129) % 48;
      v[10] = 1'b1;
      if (o < 16) begin
        v[9] = 1'b1;
        v[7] = (k == 129);
        v[2] = (o == 15);
      end else if (o < 32) begin
        v[6] = (o == 16);
        if (o == 31) begin v[1] = 1'b1; v[0] = 1'b1; end
      end else begin
        v[8] = 1'b1;
        v[5] = (o == 32);
        v[0] = (o == 47) && (w < 3);
      end
    end else begin
      v[15] = 1'b1;
    end
    v[14] = is_bwd(k - 1);
    return v;
  endfunction

  // N=W=16, LLR_LAT=3: {busy, done, llr_valid, gamma_rdwr2, mux_alpha, mux_dummy, mux_beta}
  function automatic logic [6:0] exp6(input int k);
    logic [6:0] v;
    v[6] = (k >= 1)  && (k <= 81);
    v[5] = (k == 81);
    v[4] = (k >= 68) && (k <= 83);
    v[3] = (k >= 33) && (k <= 80);
    v[2] = (k == 33);
    v[1] = (k == 49);
    v[0] = (k == 65);
    return v;
  endfunction

  initial begin
    int c_ma, c_md, c_mb, c_llr, c_a1, c_done, c_llr6;
    reset  = 1'b1;
    start  = 1'b0;
    start6 = 1'b0;
    c_ma = 0; c_md = 0; c_mb = 0; c_llr = 0; c_a1 = 0; c_done = 0; c_llr6 = 0;

    // 1. reset for three cycles, then release
    step(); step(); step();
    check("reset_vec", 32'(obs_main), 32'(exp_main(0)));
    check("reset_win", 32'(win_idx), 32'd0);
    reset = 1'b0;
    step();
    check("idle_vec", 32'(obs_main), 32'(exp_main(0)));
    check("idle6_vec", 32'(obs6), 32'(exp6(0)));

    // 2/3. clean frame with a single start pulse
    start = 1'b1;
    step();
    start = 1'b0;
    for (int k = 1; k <= 322; k++) begin
      check($sformatf("frameA k=%0d", k), 32'(obs_main), 32'(exp_main(k)));
      if (k >= 129 && k <= 320)
        check($sformatf("frameA_win k=%0d", k), 32'(win_idx), 32'((k - 129) / 48));
      c_ma  += int'(mux_alpha);
      c_md  += int'(mux_dummy);
      c_mb  += int'(mux_beta);
      c_llr += int'(llr_valid);
      c_a1  += int'(alpha_rdwr1);
      step();
    end
    check("cnt_mux_alpha", 32'(c_ma), 32'd1);
    check("cnt_mux_dummy", 32'(c_md), 32'd4);
    check("cnt_mux_beta", 32'(c_mb), 32'd4);
    check("cnt_llr_valid", 32'(c_llr), 32'd64);
    check("cnt_alpha_rdwr1", 32'(c_a1), 32'd64);

    // 4. start toggled during GAMMA, then held high through DONE
    start = 1'b1;
    step();
    for (int k = 1; k <= 322; k++) begin
      check($sformatf("frameB k=%0d", k), 32'(obs_main), 32'(exp_main(k)));
      if (k >= 65 && k <= 128) start = (k % 2 == 0);
      else                     start = (k >= 300);
      step();
    end
    check("restart_load", 32'(obs_main), 32'(exp_main(1)));
    start = 1'b0;

    // 5. reset during FWD of window 2 in the restarted frame
    for (int k = 1; k <= 230; k++) begin
      check($sformatf("frameC k=%0d", k), 32'(obs_main), 32'(exp_main(k)));
      if (k == 230) reset = 1'b1;
      step();
    end
    check("midreset_vec", 32'(obs_main), 32'(exp_main(0)));
    check("midreset_win", 32'(win_idx), 32'd0);
    reset = 1'b0;
    for (int k = 0; k < 40; k++) begin
      c_done += int'(done) + int'(busy);
      step();
    end
    check("midreset_quiet", 32'(c_done), 32'd0);

    // 6. single window, LLR latency 3
    start6 = 1'b1;
    step();
    start6 = 1'b0;
    for (int k = 1; k <= 90; k++) begin
      check($sformatf("n16 k=%0d", k), 32'(obs6), 32'(exp6(k)));
      c_llr6 += int'(llr_valid6);
      step();
    end
    check("n16_llr_count", 32'(c_llr6), 32'd16);
    check("n16_win", 32'(win_idx6), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
